shared_unit_arbiter_32: RTL and testbench

SHARED_UNIT_ARBITER_32 -- requirements
Module: shared_unit_arbiter_32

---
 rtl/shared_unit_arbiter_32_if.sv | 41 ++++
 rtl/shared_unit_arbiter_32.sv | 149 ++++++++++++++
 tb/tb_shared_unit_arbiter_32.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/shared_unit_arbiter_32_if.sv
// Requester-side bus of the shared unit arbiter.
// Two requesters share one request/response bus. Each requester owns one bit
// of every 2-bit vector; operands and the shared result are WIDTH bits.
//   req_valid  : per-requester operation request
//   req_x0/x1  : operand of requester 0 / 1
//   req_ready  : one-hot accept pulse from the arbiter
//   resp_valid : one-hot response valid to the granted requester
//   resp_ready : per-requester response acceptance
//   resp_out   : result of the granted operation, shared by both requesters
// master = requester side, slave = arbiter side.
interface shared_unit_arbiter_32_if #(
  parameter int WIDTH = 32
);
  logic [1:0]       req_valid;
  logic [WIDTH-1:0] req_x0;
  logic [WIDTH-1:0] req_x1;
  logic [1:0]       req_ready;
  logic [1:0]       resp_valid;
  logic [1:0]       resp_ready;
  logic [WIDTH-1:0] resp_out;

  modport master (
    output req_valid,
    output req_x0,
    output req_x1,
    output resp_ready,
    input  req_ready,
    input  resp_valid,
    input  resp_out
  );

  modport slave (
    input  req_valid,
    input  req_x0,
    input  req_x1,
    input  resp_ready,
    output req_ready,
    output resp_valid,
    output resp_out
  );
endinterface

// File: rtl/shared_unit_arbiter_32.sv
// Round-robin arbiter that time-shares one fixed-latency datapath unit
// between two requesters, with one operation in flight at most.
//
// Ports:
//   clk       : single clock, rising edge
//   rst       : synchronous active-high reset
//   bus       : requester bus (slave modport), see shared_unit_arbiter_32_if
//   unit_x    : operand to the shared unit
//   unit_en   : one-cycle issue strobe to the shared unit
//   unit_out  : result from the shared unit, valid LATENCY edges after issue
//   busy      : high whenever the FSM is not IDLE
//   grant     : requester owning the current or last operation
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a request; accepts the arbitration winner
// ISSUE | unit_en pulse with the latched operand, wait counter loaded
// WAIT  | counting down the unit latency, captures unit_out at zero
// RESP  | response presented to the granted requester until accepted
module shared_unit_arbiter_32 #(
  parameter int WIDTH   = 32,
  parameter int LATENCY = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  shared_unit_arbiter_32_if.slave  bus,
  output logic [WIDTH-1:0]         unit_x,
  output logic                     unit_en,
  input  logic [WIDTH-1:0]         unit_out,
  output logic                     busy,
  output logic                     grant
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

  state_t           state_q, state_d;
  logic             grant_q, grant_d;
  logic             last_grant_q, last_grant_d;
  logic [WIDTH-1:0] op_reg_q, op_reg_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [3:0]       cnt_q, cnt_d;

  logic             winner;
  logic [1:0]       req_ready_c;
  logic [1:0]       resp_valid_c;
  logic             unit_en_c;

  // Lone request wins outright; on a tie the requester that was not served
  // last goes first. last_grant resets to 1 so requester 0 wins the first tie.
  always_comb begin
    winner = bus.req_valid[1];
    if (bus.req_valid == 2'b11) begin
      winner = ~last_grant_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    op_reg_d     = op_reg_q;
    result_d     = result_q;
    cnt_d        = cnt_q;
    req_ready_c  = 2'b00;
    resp_valid_c = 2'b00;
    unit_en_c    = 1'b0;

    case (state_q)
      IDLE: begin
        if (|bus.req_valid) begin
          req_ready_c[winner] = 1'b1;
          grant_d             = winner;
          op_reg_d            = winner ? bus.req_x1 : bus.req_x0;
          state_d             = ISSUE;
        end
      end

      ISSUE: begin
        unit_en_c = 1'b1;
        cnt_d     = CNT_LOAD;
        state_d   = WAIT;
      end

      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          result_d = unit_out;
          state_d  = RESP;
        end
      end

      RESP: begin
        resp_valid_c[grant_q] = 1'b1;
        // Only the granted requester's acceptance matters here.
        if (bus.resp_ready[grant_q]) begin
          last_grant_d = grant_q;
          state_d      = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // The accept pulse must not be seen while reset is pending, since the
    // request would not actually be consumed on that edge.
    if (rst) begin
      req_ready_c = 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      op_reg_q     <= '0;
      result_q     <= '0;
      cnt_q        <= 4'd0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      op_reg_q     <= op_reg_d;
      result_q     <= result_d;
      cnt_q        <= cnt_d;
    end
  end

  // op_reg keeps the operand after issue, so unit_x stays stable until the
  // next grant replaces it.
  assign unit_x         = op_reg_q;
  assign unit_en        = unit_en_c;
  assign busy           = (state_q != IDLE);
  assign grant          = grant_q;
  assign bus.req_ready  = req_ready_c;
  assign bus.resp_valid = resp_valid_c;
  assign bus.resp_out   = result_q;

endmodule

// File: tb/tb_shared_unit_arbiter_32.sv
// Directed bench for shared_unit_arbiter_32 with a 2-edge x+x+x unit model.
module tb_shared_unit_arbiter_32;

  localparam int WIDTH   = 32;
  localparam int LATENCY = 2;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] unit_x;
  logic             unit_en;
  logic [WIDTH-1:0] unit_out;
  logic             busy;
  logic             grant;
  logic [WIDTH-1:0] unit_s1;

  int n_checks;
  int n_errors;

  shared_unit_arbiter_32_if #(.WIDTH(WIDTH)) sif ();

  shared_unit_arbiter_32 #(.WIDTH(WIDTH), .LATENCY(LATENCY)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (sif),
    .unit_x   (unit_x),
    .unit_en  (unit_en),
    .unit_out (unit_out),
    .busy     (busy),
    .grant    (grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared unit: captures x+x+x on the enable edge, presents it one edge later.
  always @(posedge clk) begin
    if (unit_en) unit_s1 <= unit_x + unit_x + unit_x;
    unit_out <= unit_s1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Single operation from requester idx, started at a negedge in IDLE.
  // While stalled, the other requester asserts req_valid and its resp_ready
  // bit, neither of which may affect the operation in flight.
  task automatic single_op(input int idx, input logic [31:0] x, input logic [31:0] exp,
                           input int stall);
    logic [1:0] oh;
    logic [1:0] other;
    oh    = (idx == 1) ? 2'b10 : 2'b01;
    other = ~oh;
    if (idx == 1) sif.req_x1 = x; else sif.req_x0 = x;
    sif.req_valid = oh;
    #1;
    check("accept_ready", {30'd0, sif.req_ready}, {30'd0, oh});
    check("accept_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    sif.req_valid = 2'b00;
    if (idx == 1) sif.req_x1 = 32'hdead_beef; else sif.req_x0 = 32'hdead_beef;
    #1;
    check("issue_en", {31'd0, unit_en}, 32'd1);
    check("issue_x", unit_x, x);
    check("issue_grant", {31'd0, grant}, idx);
    check("issue_ready", {30'd0, sif.req_ready}, 32'd0);
    @(negedge clk); #1;
    check("wait1_en", {31'd0, unit_en}, 32'd0);
    check("wait1_rv", {30'd0, sif.resp_valid}, 32'd0);
    @(negedge clk); #1;
    check("wait0_rv", {30'd0, sif.resp_valid}, 32'd0);
    check("wait0_x", unit_x, x);
    @(negedge clk); #1;
    check("resp_valid", {30'd0, sif.resp_valid}, {30'd0, oh});
    check("resp_out", sif.resp_out, exp);
    if (stall > 0) begin
      sif.req_valid  = other;
      sif.resp_ready = other;
      for (int i = 0; i < stall; i++) begin
        #1;
        check("stall_rv", {30'd0, sif.resp_valid}, {30'd0, oh});
        check("stall_out", sif.resp_out, exp);
        check("stall_ready", {30'd0, sif.req_ready}, 32'd0);
        @(negedge clk);
      end
    end
    sif.resp_ready = oh;
    #1;
    check("hs_rv", {30'd0, sif.resp_valid}, {30'd0, oh});
    @(negedge clk);
    sif.resp_ready = 2'b00;
    #1;
    check("idle_busy", {31'd0, busy}, 32'd0);
    check("idle_rv", {30'd0, sif.resp_valid}, 32'd0);
    if (stall > 0) begin
      check("pending_ready", {30'd0, sif.req_ready}, {30'd0, other});
      sif.req_valid = 2'b00;
    end
  endtask

  // Bounded wait for a response, then handshake with both resp_ready bits.
  task automatic wait_resp(input string tag, input logic [1:0] exp_rv, input logic [31:0] exp);
    int cyc;
    cyc = 0;
    while (sif.resp_valid == 2'b00 && cyc < 12) begin
      @(negedge clk); #1;
      cyc++;
    end
    check({tag, "_timeout"}, {31'd0, cyc >= 12}, 32'd0);
    check({tag, "_rv"}, {30'd0, sif.resp_valid}, {30'd0, exp_rv});
    check({tag, "_out"}, sif.resp_out, exp);
    sif.resp_ready = 2'b11;
    @(negedge clk);
    sif.resp_ready = 2'b00;
    #1;
  endtask

  initial begin
    n_checks       = 0;
    n_errors       = 0;
    rst            = 1'b1;
    sif.req_valid  = 2'b00;
    sif.req_x0     = '0;
    sif.req_x1     = '0;
    sif.resp_ready = 2'b00;

    // Reset
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready", {30'd0, sif.req_ready}, 32'd0);
    check("rst_rv", {30'd0, sif.resp_valid}, 32'd0);
    check("rst_en", {31'd0, unit_en}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_grant", {31'd0, grant}, 32'd0);
    check("rst_unit_x", unit_x, 32'd0);
    check("rst_out", sif.resp_out, 32'd0);
    rst = 1'b0;

    // Single request right after reset
    single_op(0, 32'd2, 32'd6, 0);

    // Backpressure: 4 stalled cycles in RESP
    @(negedge clk);
    single_op(0, 32'd2, 32'd6, 4);

    // Contention, from reset so last_grant is back to 1
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sif.req_x0    = 32'd5;
    sif.req_x1    = 32'd7;
    sif.req_valid = 2'b11;
    #1;
    check("cont_first_ready", {30'd0, sif.req_ready}, 32'd1);
    wait_resp("cont_a", 2'b01, 32'd15);
    check("cont_second_ready", {30'd0, sif.req_ready}, 32'd2);
    wait_resp("cont_b", 2'b10, 32'd21);
    check("cont_third_ready", {30'd0, sif.req_ready}, 32'd1);
    wait_resp("cont_c", 2'b01, 32'd15);
    sif.req_valid = 2'b00;

    // Reset during WAIT abandons the operation
    @(negedge clk);
    sif.req_x0    = 32'd9;
    sif.req_valid = 2'b01;
    @(negedge clk);
    sif.req_valid = 2'b00;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_rv", {30'd0, sif.resp_valid}, 32'd0);
    check("midrst_out", sif.resp_out, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      check("midrst_quiet", {30'd0, sif.resp_valid}, 32'd0);
    end
    single_op(0, 32'd1, 32'd3, 0);

    // Wrap-around through requester 1
    @(negedge clk);
    single_op(1, 32'h6000_0000, 32'h2000_0000, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
